cla_seq_adder: RTL and testbench
================================

Name: cla_seq_adder

Overview:
- Multi-precision add/subtract sequencer built on one shared 4-bit carry look-ahead slice.
- Processes WIDTH-bit operands one nibble per clock, LSB nibble first, with a registered carry between nibbles.
- Uses valid/ready handshakes on input and output.
- Sits where a wide adder is needed but area forbids a full-width CLA, e.g. accumulators and address arithmetic.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; not overridden by instantiators.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used for add only.
- sub  input  1  1 = A − B, 0 = A + B + cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - sum, cout, ovf and zero = 0; nibble index = 0; carry register = 0.
  - Reset wins over every other event.
  - Reset mid-RUN or mid-DONE discards the operation; no result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid at an edge:
    - latch a.
    - latch b, or ~b when sub = 1.
    - set carry register = (sub ? 1 : cin).
    - set idx = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle the slice adds nibble idx of A, nibble idx of B', and the carry register.
  - At the edge: write the 4-bit result into sum[4*idx+3:4*idx], load the carry register with the slice carry-out, increment idx.
  - When idx == NIB−1 at the edge:
    - also register cout = slice carry-out.
    - register ovf = slice carry-into-bit-3 XOR slice carry-out.
    - register zero from the full assembled sum.
    - go to DONE.
- DONE:
  - out_valid = 1; sum, cout, ovf and zero held stable.
  - in_ready = 0; in_valid is ignored.
  - On out_ready at an edge, go to IDLE.
- Latency:
  - Accept at edge T, out_valid high after edge T+NIB (4 cycles for WIDTH = 16).
  - Throughput is one operation per NIB+2 cycles when out_ready is held high.
- Outputs sum/cout/ovf/zero:
  - Retain their last value in IDLE.
  - Are undefined-free: never X after reset.
  - Upper nibbles of sum update during RUN; consumers sample only while out_valid is high.
- Wrap-around: carry-out beyond the MSB is reported only on cout; sum wraps modulo 2^WIDTH.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Package cla_pkg:
  - nibble type (4-bit logic).
  - FSM state enum {IDLE, RUN, DONE}.
  - constant NIB_W = 4.
- Sub-module cla_slice4:
  - Purely combinational 4-bit carry look-ahead slice.
  - Generate/propagate per bit; carries c1..c4 expanded in look-ahead form from g, p and c0.
  - Outputs: 4-bit sum, c4, c3 (for overflow detection).
  - One instance in cla_seq_adder.

Test Plan (WIDTH = 16):
1. Basic add: a=0x0001, b=0x0008, cin=1, sub=0.
   - sum=0x000A, cout=0, ovf=0, zero=0.
   - out_valid rises exactly 4 cycles after the accept edge.
2. Full carry ripple: a=0xFFFF, b=0x0001, cin=0.
   - sum=0x0000, cout=1, zero=1, ovf=0; carry propagates through all 4 nibbles.
3. Signed overflow: a=0x7FFF, b=0x0001, cin=0.
   - sum=0x8000, cout=0, ovf=1, zero=0.
4. Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored).
   - sum=0xFFFE, cout=0, ovf=0.
   - Repeat with a=0x0007, b=0x0005: sum=0x0002, cout=1.
5. Back-pressure: hold out_ready=0 for 3 cycles after out_valid while driving a new in_valid.
   - out_valid and result stay stable; in_ready=0; the new operands are not captured.
   - After out_ready, in_ready=1 on the next cycle.
6. Reset mid-operation: assert rst_n=0 after 2 RUN cycles.
   - Next cycle: in_ready=1, out_valid=0, sum=0x0000.
   - out_valid is never asserted for the aborted operation.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry look-ahead adder.
package cla_pkg;

    localparam int unsigned NIB_W = 4;

    typedef logic [NIB_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry look-ahead slice; c3 is exposed for signed-overflow detection.
module cla_slice4
    import cla_pkg::*;
(
    input  nibble_t a,
    input  nibble_t b,
    input  logic    c0,
    output nibble_t s,
    output logic    c3,
    output logic    c4
);

    nibble_t g;
    nibble_t p;
    logic    c1;
    logic    c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded directly from g, p and c0 so no carry waits on another.
    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-precision add/subtract: one shared CLA slice walks the operands LSB nibble first.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t           state,     state_nxt;
    logic             in_ready_nxt;
    logic             out_valid_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;
    logic             zero_nxt;
    logic [WIDTH-1:0] a_r,       a_nxt;
    logic [WIDTH-1:0] b_r,       b_nxt;
    logic             carry_r,   carry_nxt;
    logic [IDX_W-1:0] idx,       idx_nxt;

    nibble_t slice_a;
    nibble_t slice_b;
    nibble_t slice_s;
    logic    slice_c3;
    logic    slice_c4;

    assign slice_a = a_r[int'(idx) * NIB_W +: NIB_W];
    assign slice_b = b_r[int'(idx) * NIB_W +: NIB_W];

    cla_slice4 u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .c0 (carry_r),
        .s  (slice_s),
        .c3 (slice_c3),
        .c4 (slice_c4)
    );

    // State, handshake and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            idx       <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            sum       <= sum_nxt;
            cout      <= cout_nxt;
            ovf       <= ovf_nxt;
            zero      <= zero_nxt;
            a_r       <= a_nxt;
            b_r       <= b_nxt;
            carry_r   <= carry_nxt;
            idx       <= idx_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_nxt     = state;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;
        sum_nxt       = sum;
        cout_nxt      = cout;
        ovf_nxt       = ovf;
        zero_nxt      = zero;
        a_nxt         = a_r;
        b_nxt         = b_r;
        carry_nxt     = carry_r;
        idx_nxt       = idx;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so the inversion and the +1 happen at capture.
                    a_nxt        = a;
                    b_nxt        = sub ? ~b : b;
                    carry_nxt    = sub ? 1'b1 : cin;
                    idx_nxt      = '0;
                    in_ready_nxt = 1'b0;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                sum_nxt[int'(idx) * NIB_W +: NIB_W] = slice_s;
                carry_nxt = slice_c4;
                idx_nxt   = idx + IDX_W'(1);
                if (idx == IDX_W'(NIB - 1)) begin
                    cout_nxt      = slice_c4;
                    ovf_nxt       = slice_c3 ^ slice_c4;
                    zero_nxt      = (sum_nxt == '0);
                    idx_nxt       = '0;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                out_valid_nxt = 1'b0;
                in_ready_nxt  = 1'b1;
                state_nxt     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder: directed vector table, random ops vs. arithmetic model, handshake corners.
module tb_cla_seq_adder;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, signed range test for overflow.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         input logic ms, output logic [W-1:0] es, output logic eco,
                         output logic eov, output logic ez);
        int ua = int'(ma);
        int ub = int'(mb);
        int sa = int'($signed(ma));
        int sb = int'($signed(mb));
        int ur;
        int sr;
        if (ms) begin
            ur  = ua - ub;
            sr  = sa - sb;
            eco = (ua >= ub);
        end else begin
            ur  = ua + ub + int'(mc);
            sr  = sa + sb + int'(mc);
            eco = (ur > 65535);
        end
        es  = W'(ur);
        eov = (sr > 32767) || (sr < -32768);
        ez  = (es == '0);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, output logic [W-1:0] rs, output logic rc,
                          output logic ro, output logic rz);
        int n = 0;
        int lat = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_before_op", 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        rs = sum; rc = cout; ro = ovf; rz = zero;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    vec_t         vecs[8];
    logic [W-1:0] rs;
    logic         rc;
    logic         ro;
    logic         rz;
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    logic         ez;

    initial begin
        vecs[0] = '{16'h0001, 16'h0008, 1'b1, 1'b0, 16'h000A, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        step();
        step();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_flags",     32'({cout, ovf, zero}), 32'd0);
        rst_n = 1'b1;
        step();

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, rz);
            chk($sformatf("vec%0d_sum", i),  32'(rs), 32'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].co));
            chk($sformatf("vec%0d_ovf", i),  32'(ro), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_zero", i), 32'(rz), 32'(vecs[i].z));
        end

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rcin;
            logic         rsub;
            ra   = W'($urandom);
            rb   = (i % 8 == 0) ? ra : W'($urandom);
            rcin = 1'($urandom);
            rsub = 1'($urandom);
            model(ra, rb, rcin, rsub, es, eco, eov, ez);
            run_op(ra, rb, rcin, rsub, rs, rc, ro, rz);
            chk($sformatf("rnd%0d_sum", i),   32'(rs), 32'(es));
            chk($sformatf("rnd%0d_flags", i), 32'({rc, ro, rz}), 32'({eco, eov, ez}));
            repeat ($urandom_range(0, 2)) step();
        end

        // Back-pressure: result held, new operands ignored while DONE.
        begin
            int n = 0;
            a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            while (!out_valid && n < 20) begin
                step();
                n++;
            end
            chk("bp_reached_done", 32'(out_valid), 32'd1);
            a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                step();
                chk($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
                chk($sformatf("bp%0d_in_ready", k),  32'(in_ready),  32'd0);
                chk($sformatf("bp%0d_sum", k),       32'(sum),       32'h2345);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("bp_release_in_ready",  32'(in_ready),  32'd1);
            chk("bp_release_out_valid", 32'(out_valid), 32'd0);
            chk("bp_idle_sum_retained", 32'(sum),       32'h2345);
        end

        // Reset two cycles into RUN aborts the operation.
        begin
            int seen = 0;
            a = 16'h1111; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            step();
            rst_n = 1'b0;
            step();
            chk("abort_in_ready",  32'(in_ready),  32'd1);
            chk("abort_out_valid", 32'(out_valid), 32'd0);
            chk("abort_sum",       32'(sum),       32'd0);
            chk("abort_flags",     32'({cout, ovf, zero}), 32'd0);
            rst_n = 1'b1;
            for (int k = 0; k < 10; k++) begin
                step();
                if (out_valid) seen++;
            end
            chk("abort_no_result", 32'(seen), 32'd0);
        end

        model(16'hABCD, 16'h1234, 1'b0, 1'b1, es, eco, eov, ez);
        run_op(16'hABCD, 16'h1234, 1'b0, 1'b1, rs, rc, ro, rz);
        chk("post_abort_sum",   32'(rs), 32'(es));
        chk("post_abort_flags", 32'({rc, ro, rz}), 32'({eco, eov, ez}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
